// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter producing one-hot tri-state enables with a dead cycle between owners.
// Latency: 1 cycle from req sampled to grant visible; one TURN cycle after every release.
// Backpressure: none; an owner holds at most MAX_HOLD cycles and is never preempted.
module tri_bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 4,
    parameter int IDX_W    = 2
) (
    input  logic             clock,
    input  logic             reset_b,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic             bus_en,
    output logic [IDX_W-1:0] owner
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;

    logic             win_vld;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] scan_idx;
    int               scan_pos;

    // First requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        scan_pos = 0;
        scan_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_pos = int'(ptr) + i;
            if (scan_pos >= N_REQ) begin
                scan_pos = scan_pos - N_REQ;
            end
            scan_idx = IDX_W'(scan_pos);
            if (!win_vld && req[scan_idx]) begin
                win_vld = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state  <= IDLE;
            ptr    <= '0;
            cnt    <= '0;
            grant  <= '0;
            bus_en <= 1'b0;
            owner  <= '0;
        end else begin
            case (state)
                IDLE, TURN: begin
                    if (win_vld) begin
                        grant  <= N_REQ'(1) << win_idx;
                        owner  <= win_idx;
                        bus_en <= 1'b1;
                        cnt    <= '0;
                        state  <= GRANT;
                    end else begin
                        state  <= IDLE;
                    end
                end
                GRANT: begin
                    // A single low cycle on the owner's req ends ownership.
                    if (!req[owner] || cnt == CNT_W'(MAX_HOLD - 1)) begin
                        grant  <= '0;
                        bus_en <= 1'b0;
                        owner  <= '0;
                        ptr    <= (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);
                        state  <= TURN;
                    end else begin
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    grant  <= '0;
                    bus_en <= 1'b0;
                    owner  <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed bench for tri_bus_arbiter (N_REQ=4, MAX_HOLD=4) with hand-computed grant vectors.
module tb_tri_bus_arbiter;

    logic       clock = 1'b0;
    logic       reset_b;
    logic [3:0] req;
    logic [3:0] grant;
    logic       bus_en;
    logic [1:0] owner;

    int errors = 0;
    int checks = 0;

    tri_bus_arbiter #(
        .N_REQ    (4),
        .MAX_HOLD (4),
        .IDX_W    (2)
    ) dut (
        .clock   (clock),
        .reset_b (reset_b),
        .req     (req),
        .grant   (grant),
        .bus_en  (bus_en),
        .owner   (owner)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compares grant, bus_en, owner and the one-hot invariant against an expected grant vector.
    task automatic chk_out(input string tag, input logic [3:0] exp_g);
        logic [1:0] exp_o;
        exp_o = 2'd0;
        for (int b = 0; b < 4; b++) begin
            if (exp_g[b]) exp_o = 2'(b);
        end
        chk({tag, "_grant"},  16'(grant),  16'(exp_g));
        chk({tag, "_bus_en"}, 16'(bus_en), 16'(|exp_g));
        chk({tag, "_owner"},  16'(owner),  16'(exp_o));
        chk({tag, "_onehot"}, 16'($countones(grant) <= 1), 16'd1);
    endtask

    initial begin
        reset_b = 1'b0;
        req     = 4'b0000;
        #2;
        chk_out("reset", 4'b0000);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_b = 1'b1;

        // Single requester dropping after two grant cycles.
        req = 4'b0100;
        tick(); chk_out("single_c1", 4'b0100);
        tick(); chk_out("single_c2", 4'b0100);
        req = 4'b0000;
        tick(); chk_out("single_turn", 4'b0000);
        tick(); chk_out("single_idle1", 4'b0000);
        tick(); chk_out("single_idle2", 4'b0000);

        // ptr is 3 here, so req=0010 wins via wrap; then reset asynchronously mid-grant.
        req = 4'b0010;
        tick(); chk_out("pre_reset", 4'b0010);
        #2 reset_b = 1'b0;
        #1 chk_out("async_reset", 4'b0000);
        req = 4'b1000;
        @(negedge clock);
        reset_b = 1'b1;
        tick(); chk_out("post_reset", 4'b1000);
        req = 4'b0000;
        tick(); chk_out("post_reset_turn", 4'b0000);
        tick(); chk_out("post_reset_idle", 4'b0000);

        // Full round-robin with all requesting, ending on the wrap back to 0.
        req = 4'b1111;
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < 4; c++) begin
                tick(); chk_out($sformatf("rr_p%0d_c%0d", p, c), 4'b0001 << (p % 4));
            end
            if (p < 4) begin
                tick(); chk_out($sformatf("rr_turn%0d", p), 4'b0000);
            end
        end
        req = 4'b0000;
        tick(); chk_out("rr_end_turn", 4'b0000);
        tick(); chk_out("rr_end_idle", 4'b0000);

        // Single persistent requester: 4 on / 1 off.
        req = 4'b0001;
        for (int i = 0; i < 14; i++) begin
            tick(); chk_out($sformatf("hold_%0d", i), (i % 5 == 4) ? 4'b0000 : 4'b0001);
        end
        req = 4'b0000;
        tick(); chk_out("hold_end_turn", 4'b0000);
        tick(); chk_out("hold_end_idle", 4'b0000);

        // Owner 0 drops on the same edge req[3] rises.
        req = 4'b0001;
        tick(); chk_out("coll_own1", 4'b0001);
        tick(); chk_out("coll_own2", 4'b0001);
        req = 4'b1000;
        tick(); chk_out("coll_turn", 4'b0000);
        tick(); chk_out("coll_new", 4'b1000);
        req = 4'b0000;
        tick(); chk_out("coll_end_turn", 4'b0000);
        tick(); chk_out("coll_end_idle", 4'b0000);

        // Owner 1 hits the hold limit with 0011 pending; ptr=2 wraps to requester 0.
        req = 4'b0010;
        tick(); chk_out("fair_own0", 4'b0010);
        req = 4'b0011;
        for (int i = 1; i < 4; i++) begin
            tick(); chk_out($sformatf("fair_own%0d", i), 4'b0010);
        end
        tick(); chk_out("fair_turn", 4'b0000);
        tick(); chk_out("fair_next", 4'b0001);
        req = 4'b0000;
        tick(); chk_out("fair_end_turn", 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
